// File: rtl/id_exe_stage_reg_if.sv
// Signal bundle between decode/register-read and the ID/EXE pipeline register.
// Master is the pipeline side that drives ID fields; slave is the register itself.
interface id_exe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 4,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
);
  // Flow control: flush_i beats stall_i beats the internal load-use check.
  // id_hold_o is a same-cycle request telling IF/ID to present its current
  // instruction again on the next cycle.
  logic              stall_i;
  logic              flush_i;

  logic              id_valid;
  logic              id_wreg;
  logic              id_m2reg;
  logic              id_wmem;
  logic              id_shift;
  logic              id_aluimm;
  logic              id_regrt;
  logic [ALUC_W-1:0] id_aluc;
  logic [DATA_W-1:0] id_data_a;
  logic [DATA_W-1:0] id_data_b;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [TAG_W-1:0]  id_ins_type;
  logic [TAG_W-1:0]  id_ins_number;

  logic              e_valid;
  logic              e_wreg;
  logic              e_m2reg;
  logic              e_wmem;
  logic              e_shift;
  logic              e_aluimm;
  logic              e_regrt;
  logic [ALUC_W-1:0] e_aluc;
  logic [DATA_W-1:0] e_data_a;
  logic [DATA_W-1:0] e_data_b;
  logic [DATA_W-1:0] e_imm;
  logic [REG_AW-1:0] e_rt;
  logic [REG_AW-1:0] e_rd;
  logic [TAG_W-1:0]  e_ins_type;
  logic [TAG_W-1:0]  e_ins_number;

  logic              id_hold_o;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output stall_i, flush_i,
    output id_valid, id_wreg, id_m2reg, id_wmem, id_shift, id_aluimm, id_regrt,
    output id_aluc, id_data_a, id_data_b, id_imm, id_rs, id_rt, id_rd,
    output id_uses_rs, id_uses_rt, id_ins_type, id_ins_number,
    input  e_valid, e_wreg, e_m2reg, e_wmem, e_shift, e_aluimm, e_regrt,
    input  e_aluc, e_data_a, e_data_b, e_imm, e_rt, e_rd,
    input  e_ins_type, e_ins_number,
    input  id_hold_o, bubble_cnt, flush_cnt
  );

  modport slave (
    input  stall_i, flush_i,
    input  id_valid, id_wreg, id_m2reg, id_wmem, id_shift, id_aluimm, id_regrt,
    input  id_aluc, id_data_a, id_data_b, id_imm, id_rs, id_rt, id_rd,
    input  id_uses_rs, id_uses_rt, id_ins_type, id_ins_number,
    output e_valid, e_wreg, e_m2reg, e_wmem, e_shift, e_aluimm, e_regrt,
    output e_aluc, e_data_a, e_data_b, e_imm, e_rt, e_rd,
    output e_ins_type, e_ins_number,
    output id_hold_o, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with valid bit, stall/flush control, load-use
// bubble insertion and saturating bubble/flush counters.
module id_exe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 4,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  id_exe_stage_reg_if.slave bus
);

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_KILL   = 2'd3
  } action_e;

  action_e           action;
  logic [REG_AW-1:0] e_dest;
  logic              rs_match;
  logic              rt_match;
  logic              hazard;

  logic              e_valid_q,  e_valid_d;
  logic              e_wreg_q,   e_wreg_d;
  logic              e_m2reg_q,  e_m2reg_d;
  logic              e_wmem_q,   e_wmem_d;
  logic              e_shift_q,  e_shift_d;
  logic              e_aluimm_q, e_aluimm_d;
  logic              e_regrt_q,  e_regrt_d;
  logic [ALUC_W-1:0] e_aluc_q,   e_aluc_d;
  logic [DATA_W-1:0] e_data_a_q, e_data_a_d;
  logic [DATA_W-1:0] e_data_b_q, e_data_b_d;
  logic [DATA_W-1:0] e_imm_q,    e_imm_d;
  logic [REG_AW-1:0] e_rt_q,     e_rt_d;
  logic [REG_AW-1:0] e_rd_q,     e_rd_d;
  logic [TAG_W-1:0]  e_ins_type_q,   e_ins_type_d;
  logic [TAG_W-1:0]  e_ins_number_q, e_ins_number_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;

  // Load-use check: the instruction in EXE is a load whose result the ID
  // instruction wants now. Register 0 is hard-wired and never forwards.
  always_comb begin
    e_dest   = e_regrt_q ? e_rt_q : e_rd_q;
    rs_match = bus.id_uses_rs && (bus.id_rs == e_dest);
    rt_match = bus.id_uses_rt && (bus.id_rt == e_dest);
    hazard   = e_valid_q && e_m2reg_q && e_wreg_q && (e_dest != '0) &&
               bus.id_valid && (rs_match || rt_match);
  end

  always_comb begin
    if (bus.flush_i) begin
      action = ACT_KILL;
    end else if (bus.stall_i) begin
      action = ACT_HOLD;
    end else if (hazard) begin
      action = ACT_BUBBLE;
    end else begin
      action = ACT_LOAD;
    end
  end

  always_comb begin
    e_valid_d      = e_valid_q;
    e_wreg_d       = e_wreg_q;
    e_m2reg_d      = e_m2reg_q;
    e_wmem_d       = e_wmem_q;
    e_shift_d      = e_shift_q;
    e_aluimm_d     = e_aluimm_q;
    e_regrt_d      = e_regrt_q;
    e_aluc_d       = e_aluc_q;
    e_data_a_d     = e_data_a_q;
    e_data_b_d     = e_data_b_q;
    e_imm_d        = e_imm_q;
    e_rt_d         = e_rt_q;
    e_rd_d         = e_rd_q;
    e_ins_type_d   = e_ins_type_q;
    e_ins_number_d = e_ins_number_q;
    bubble_cnt_d   = bubble_cnt_q;
    flush_cnt_d    = flush_cnt_q;

    // Non-architectural fields follow ID on every advancing edge, even when
    // the slot is being invalidated, so EXE debug views stay meaningful.
    if (action != ACT_HOLD) begin
      e_shift_d      = bus.id_shift;
      e_aluimm_d     = bus.id_aluimm;
      e_regrt_d      = bus.id_regrt;
      e_aluc_d       = bus.id_aluc;
      e_data_a_d     = bus.id_data_a;
      e_data_b_d     = bus.id_data_b;
      e_imm_d        = bus.id_imm;
      e_rt_d         = bus.id_rt;
      e_rd_d         = bus.id_rd;
      e_ins_type_d   = bus.id_ins_type;
      e_ins_number_d = bus.id_ins_number;
    end

    case (action)
      ACT_LOAD: begin
        e_valid_d = bus.id_valid;
        e_wreg_d  = bus.id_wreg  & bus.id_valid;
        e_m2reg_d = bus.id_m2reg & bus.id_valid;
        e_wmem_d  = bus.id_wmem  & bus.id_valid;
      end
      ACT_BUBBLE: begin
        e_valid_d = 1'b0;
        e_wreg_d  = 1'b0;
        e_m2reg_d = 1'b0;
        e_wmem_d  = 1'b0;
        if (bubble_cnt_q != '1) begin
          bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
      end
      ACT_KILL: begin
        e_valid_d = 1'b0;
        e_wreg_d  = 1'b0;
        e_m2reg_d = 1'b0;
        e_wmem_d  = 1'b0;
        if (flush_cnt_q != '1) begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid_q      <= 1'b0;
      e_wreg_q       <= 1'b0;
      e_m2reg_q      <= 1'b0;
      e_wmem_q       <= 1'b0;
      e_shift_q      <= 1'b0;
      e_aluimm_q     <= 1'b0;
      e_regrt_q      <= 1'b0;
      e_aluc_q       <= '0;
      e_data_a_q     <= '0;
      e_data_b_q     <= '0;
      e_imm_q        <= '0;
      e_rt_q         <= '0;
      e_rd_q         <= '0;
      e_ins_type_q   <= '0;
      e_ins_number_q <= '0;
      bubble_cnt_q   <= '0;
      flush_cnt_q    <= '0;
    end else begin
      e_valid_q      <= e_valid_d;
      e_wreg_q       <= e_wreg_d;
      e_m2reg_q      <= e_m2reg_d;
      e_wmem_q       <= e_wmem_d;
      e_shift_q      <= e_shift_d;
      e_aluimm_q     <= e_aluimm_d;
      e_regrt_q      <= e_regrt_d;
      e_aluc_q       <= e_aluc_d;
      e_data_a_q     <= e_data_a_d;
      e_data_b_q     <= e_data_b_d;
      e_imm_q        <= e_imm_d;
      e_rt_q         <= e_rt_d;
      e_rd_q         <= e_rd_d;
      e_ins_type_q   <= e_ins_type_d;
      e_ins_number_q <= e_ins_number_d;
      bubble_cnt_q   <= bubble_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign bus.e_valid      = e_valid_q;
  assign bus.e_wreg       = e_wreg_q;
  assign bus.e_m2reg      = e_m2reg_q;
  assign bus.e_wmem       = e_wmem_q;
  assign bus.e_shift      = e_shift_q;
  assign bus.e_aluimm     = e_aluimm_q;
  assign bus.e_regrt      = e_regrt_q;
  assign bus.e_aluc       = e_aluc_q;
  assign bus.e_data_a     = e_data_a_q;
  assign bus.e_data_b     = e_data_b_q;
  assign bus.e_imm        = e_imm_q;
  assign bus.e_rt         = e_rt_q;
  assign bus.e_rd         = e_rd_q;
  assign bus.e_ins_type   = e_ins_type_q;
  assign bus.e_ins_number = e_ins_number_q;
  assign bus.bubble_cnt   = bubble_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

  // A flush discards whatever ID holds, so there is nothing left to hold.
  assign bus.id_hold_o = (hazard | bus.stall_i) & ~bus.flush_i;

endmodule
